// File: rtl/alu_serial_sequencer_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// master issues ops; slave is the sequencer.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             ready;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, opa, opb,
    input  ready, done, error, result,
    input  carry_out, overflow, zero
  );

  modport slave (
    input  start, op, opa, opb,
    output ready, done, error, result,
    output carry_out, overflow, zero
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Drives an external 1-bit ALU slice LSB-first over WIDTH cycles,
// closing the carry loop through a register and assembling the word.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_serial_sequencer_if.slave bus,
  output logic                 alu_a,
  output logic                 alu_b,
  output logic                 alu_carry_in,
  output logic [3:0]           alu_op,
  input  logic                 alu_result,
  input  logic                 alu_carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             cy_q;
  logic             ov_q;
  logic             zr_q;
  logic             err_q;
  logic             op_ok;
  logic             arith;
  logic             last;
  logic [WIDTH-1:0] res_next;

  // Decode whether the requested op is one the slice supports
  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      (bus.op == OP_AND),
      (bus.op == OP_OR),
      (bus.op == OP_ADD),
      (bus.op == OP_SUB),
      (bus.op == OP_NOR): op_ok = 1'b1;
      default:            op_ok = 1'b0;
    endcase
  end

  assign arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign res_next = {alu_result, res_sh[WIDTH-1:1]};

  // Slice drive: active only while running, idle-zero otherwise
  always_comb begin
    alu_a        = 1'b0;
    alu_b        = 1'b0;
    alu_carry_in = 1'b0;
    alu_op       = 4'b0000;
    if (state == S_RUN) begin
      alu_a        = a_sh[0];
      alu_b        = b_sh[0];
      alu_op       = op_q;
      alu_carry_in = (cnt == '0) ? op_q[2] : carry_q;
    end
  end

  // Sequencer FSM, datapath shift registers and result/flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      zr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          err_q <= 1'b0;
          if (bus.start) begin
            if (op_ok) begin
              a_sh  <= bus.opa;
              b_sh  <= bus.opb;
              op_q  <= bus.op;
              cnt   <= '0;
              state <= S_RUN;
            end else begin
              res_q <= '0;
              cy_q  <= 1'b0;
              ov_q  <= 1'b0;
              zr_q  <= 1'b0;
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          carry_q <= alu_carry_out;
          cnt     <= cnt + 1'b1;
          if (last) begin
            res_q <= res_next;
            zr_q  <= (res_next == '0);
            if (arith) begin
              cy_q <= alu_carry_out;
              ov_q <= alu_carry_out ^ alu_carry_in;
            end else begin
              cy_q <= 1'b0;
              ov_q <= 1'b0;
            end
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = (state != S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.error     = err_q;
  assign bus.result    = res_q;
  assign bus.carry_out = cy_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zr_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench: sequencer plus a behavioural 1-bit slice, checked against
// a word-level arithmetic model with directed and random ops.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_a;
  logic       alu_b;
  logic       alu_carry_in;
  logic [3:0] alu_op;
  logic       alu_result;
  logic       alu_carry_out;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer_if #(.WIDTH(W)) bus ();

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out)
  );

  // Classic 1-bit ALU slice: Ainvert, Binvert, 2-bit function select
  logic sa, sb;
  always_comb begin
    sa = alu_op[3] ? ~alu_a : alu_a;
    sb = alu_op[2] ? ~alu_b : alu_b;
    case (alu_op[1:0])
      2'b00:   alu_result = sa & sb;
      2'b01:   alu_result = sa | sb;
      default: alu_result = sa ^ sb ^ alu_carry_in;
    endcase
    alu_carry_out = (sa & sb) | (sa & alu_carry_in) | (sb & alu_carry_in);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit supp(input logic [3:0] op);
    return op == 4'd0 || op == 4'd1 || op == 4'd2 ||
           op == 4'd6 || op == 4'd12;
  endfunction

  // Word-level reference: plain arithmetic on whole operands
  function automatic void model(input logic [3:0] op,
                                input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic c,
                                output logic v, output logic e);
    logic [8:0] s;
    r = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd12: r = ~(a | b);
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd6: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op at the current negedge, wait for done, check outputs
  task automatic run_op(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit pulse_mid);
    logic [7:0] er, seq, eseq, bb;
    logic ec, ev, ee;
    int n;
    bit got;
    int sum;
    model(op, a, b, er, ec, ev, ee);
    chk("ready_pre", bus.ready, 1);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opa = 8'($urandom);
    bus.opb = 8'($urandom);
    bus.op  = 4'($urandom);
    n = 0; got = 0; seq = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1;
      else begin
        if (n <= W) seq[n-1] = alu_carry_in;
        if (pulse_mid && n == 3) begin
          chk("ready_run", bus.ready, 0);
          bus.start = 1'b1; bus.op = 4'd0;
        end
        if (pulse_mid && n == 4) bus.start = 1'b0;
      end
    end
    if (!got) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("latency", n, ee ? 1 : W + 1);
    chk("result", bus.result, er);
    chk("carry_out", bus.carry_out, ec);
    chk("overflow", bus.overflow, ev);
    chk("zero", bus.zero, (!ee && er == 8'h00));
    chk("error", bus.error, ee);
    chk("alu_op_idle", alu_op, 0);
    if (op == 4'd2 || op == 4'd6) begin
      bb = (op == 4'd6) ? ~b : b;
      for (int i = 0; i < W; i++) begin
        sum = int'(a & 8'((9'd1 << i) - 1)) + int'(bb & 8'((9'd1 << i) - 1))
            + ((op == 4'd6) ? 1 : 0);
        eseq[i] = sum[i];
      end
      chk("cin_seq", seq, eseq);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    chk("done_drop", bus.done, 0);
  endtask

  int t0, t1;
  logic [3:0] rop;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 4'd0; bus.opa = '0; bus.opb = '0;
    #12;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.error, bus.carry_out, bus.overflow, bus.zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd2, 8'h5A, 8'h3C, 0); idle();
    run_op(4'd6, 8'h10, 8'h10, 0); idle();
    run_op(4'd0, 8'hF0, 8'h3C, 0); idle();
    run_op(4'd1, 8'hF0, 8'h0F, 0); idle();
    run_op(4'd12, 8'hF0, 8'h0F, 0); idle();
    run_op(4'd7, 8'h12, 8'h34, 0); idle();

    run_op(4'd2, 8'h11, 8'h22, 1);
    t0 = cyc;
    run_op(4'd2, 8'h7F, 8'h01, 0);
    t1 = cyc;
    chk("b2b_gap", t1 - t0, W + 1);
    idle();

    bus.start = 1'b1; bus.op = 4'd2; bus.opa = 8'h33; bus.opb = 8'h44;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_flags", {bus.error, bus.carry_out, bus.overflow}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd2, 8'hFF, 8'h01, 0); idle();

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: rop = 4'd0;
        1: rop = 4'd1;
        2: rop = 4'd2;
        3: rop = 4'd6;
        4: rop = 4'd12;
        default: begin
          rop = 4'($urandom_range(0, 15));
          while (supp(rop)) rop = 4'($urandom_range(0, 15));
        end
      endcase
      run_op(rop, 8'($urandom), 8'($urandom), k[2]);
      if (k[0]) idle();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
